// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards results from
// EX/MEM and MEM/WB, stalls on load-use hazards and counts stall cycles.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [RA_W-1:0]  in_rs1_addr,
  input  logic [RA_W-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_alu_op,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             flush,
  input  logic             exm_reg_write,
  input  logic             exm_mem_read,
  input  logic [RA_W-1:0]  exm_rd_addr,
  input  logic [XLEN-1:0]  exm_result,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  operand1,
  output logic [XLEN-1:0]  operand2,
  output logic [2:0]       alu_op,
  output logic [XLEN-1:0]  out_store_data,
  output logic [XLEN-1:0]  out_pc,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [RA_W-1:0]  r_rs1_addr;
  logic [RA_W-1:0]  r_rs2_addr;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic             r_use_imm;
  logic [2:0]       r_alu_op;
  logic [RA_W-1:0]  r_rd_addr;
  logic             r_reg_write;
  logic             r_mem_read;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;
  logic             w_load_use;
  logic             w_fire;
  logic             w_accept;

  // rs1 forwarding; a load in EX/MEM has no data yet, so it is never a source
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (r_rs1_addr == '0) begin
      w_fwd_rs1 = '0;
    end else if (exm_reg_write && !exm_mem_read && exm_rd_addr == r_rs1_addr) begin
      w_fwd_rs1 = exm_result;
    end else if (wb_reg_write && wb_rd_addr == r_rs1_addr) begin
      w_fwd_rs1 = wb_data;
    end
  end

  // rs2 forwarding, same priority as rs1
  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (r_rs2_addr == '0) begin
      w_fwd_rs2 = '0;
    end else if (exm_reg_write && !exm_mem_read && exm_rd_addr == r_rs2_addr) begin
      w_fwd_rs2 = exm_result;
    end else if (wb_reg_write && wb_rd_addr == r_rs2_addr) begin
      w_fwd_rs2 = wb_data;
    end
  end

  // Hazard detection, handshake and output selection
  always_comb begin
    // rs2 is checked even for immediate ops since it also feeds store data
    w_load_use = r_valid && exm_reg_write && exm_mem_read && (exm_rd_addr != '0) &&
                 ((exm_rd_addr == r_rs1_addr) || (exm_rd_addr == r_rs2_addr));
    out_valid  = r_valid && !w_load_use;
    w_fire     = out_valid && out_ready;
    in_ready   = !r_valid || w_fire;
    w_accept   = in_valid && in_ready;
  end

  assign operand1       = w_fwd_rs1;
  assign operand2       = r_use_imm ? r_imm : w_fwd_rs2;
  assign out_store_data = w_fwd_rs2;
  assign alu_op         = r_alu_op;
  assign out_pc         = r_pc;
  assign out_rd_addr    = r_rd_addr;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign stall_cnt      = r_stall_cnt;

  // Pipeline entry: reset, flush, capture, drain, or refresh sources while held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_op    <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= in_pc;
      r_rs1_addr  <= in_rs1_addr;
      r_rs2_addr  <= in_rs2_addr;
      r_rs1_data  <= in_rs1_data;
      r_rs2_data  <= in_rs2_data;
      r_imm       <= in_imm;
      r_use_imm   <= in_use_imm;
      r_alu_op    <= in_alu_op;
      r_rd_addr   <= in_rd_addr;
      r_reg_write <= in_reg_write;
      r_mem_read  <= in_mem_read;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Latch forwarded values so a producer retiring mid-stall is not lost
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_load_use && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (small stall counter for saturation).
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [RA_W-1:0]  in_rs1_addr;
  logic [RA_W-1:0]  in_rs2_addr;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic             in_use_imm;
  logic [2:0]       in_alu_op;
  logic [RA_W-1:0]  in_rd_addr;
  logic             in_reg_write;
  logic             in_mem_read;
  logic             flush;
  logic             exm_reg_write;
  logic             exm_mem_read;
  logic [RA_W-1:0]  exm_rd_addr;
  logic [XLEN-1:0]  exm_result;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_rd_addr;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  operand1;
  logic [XLEN-1:0]  operand2;
  logic [2:0]       alu_op;
  logic [XLEN-1:0]  out_store_data;
  logic [XLEN-1:0]  out_pc;
  logic [RA_W-1:0]  out_rd_addr;
  logic             out_reg_write;
  logic             out_mem_read;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN  (XLEN),
    .RA_W  (RA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_use_imm     (in_use_imm),
    .in_alu_op      (in_alu_op),
    .in_rd_addr     (in_rd_addr),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .flush          (flush),
    .exm_reg_write  (exm_reg_write),
    .exm_mem_read   (exm_mem_read),
    .exm_rd_addr    (exm_rd_addr),
    .exm_result     (exm_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd_addr     (wb_rd_addr),
    .wb_data        (wb_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .operand1       (operand1),
    .operand2       (operand2),
    .alu_op         (alu_op),
    .out_store_data (out_store_data),
    .out_pc         (out_pc),
    .out_rd_addr    (out_rd_addr),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .stall_cnt      (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 2 time units after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic use_imm,
                             input logic [2:0] op, input logic [4:0] rd);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rs1_addr  = rs1;
    in_rs1_data  = d1;
    in_rs2_addr  = rs2;
    in_rs2_data  = d2;
    in_imm       = imm;
    in_use_imm   = use_imm;
    in_alu_op    = op;
    in_rd_addr   = rd;
    in_reg_write = 1'b1;
    in_mem_read  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0; in_alu_op = '0;
    in_rd_addr = '0; in_reg_write = 1'b0; in_mem_read = 1'b0; flush = 1'b0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd_addr = '0; exm_result = '0;
    wb_reg_write = 1'b0; wb_rd_addr = '0; wb_data = '0; out_ready = 1'b0;

    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_operand1", operand1, 32'd0);
    chk("reset_operand2", operand2, 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    // Basic capture: x1=5, x2=7, ADD
    drive_instr(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 3'b000, 5'd4);
    tick();
    in_valid = 1'b0;
    #1;
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_operand1", operand1, 32'd5);
    chk("basic_operand2", operand2, 32'd7);
    chk("basic_alu_op", 32'(alu_op), 32'd0);
    chk("basic_out_pc", out_pc, 32'h100);
    chk("basic_rd_addr", 32'(out_rd_addr), 32'd4);
    chk("basic_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("hold_in_ready", 32'(in_ready), 32'd0);

    // Forwarding priority, all within one cycle
    exm_reg_write = 1'b1; exm_rd_addr = 5'd1; exm_result = 32'd100;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd1; wb_data = 32'd200;
    #1;
    chk("fwd_exm_priority", operand1, 32'd100);
    exm_mem_read = 1'b1;
    #1;
    chk("fwd_exm_load_skipped", operand1, 32'd200);
    exm_mem_read = 1'b0; exm_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    #1;
    chk("fwd_rd0_stored", operand1, 32'd5);
    exm_reg_write = 1'b0; wb_reg_write = 1'b0;
    out_ready = 1'b1;
    tick();
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // rs1 = x0 reads zero even with a producer targeting x0
    drive_instr(32'h104, 5'd0, 32'h1234, 5'd2, 32'd9, 32'd0, 1'b0, 3'b011, 5'd4);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 32'd99;
    #1;
    chk("x0_operand1", operand1, 32'd0);
    chk("x0_operand2", operand2, 32'd9);
    exm_reg_write = 1'b0;
    out_ready = 1'b1;
    tick();

    // Load-use on rs2 with use_imm set
    drive_instr(32'h108, 5'd0, 32'd0, 5'd3, 32'h11, 32'hFFFF_FFFC, 1'b1, 3'b001, 5'd6);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd3;
    #1;
    chk("lu_out_valid", 32'(out_valid), 32'd0);
    chk("lu_in_ready", 32'(in_ready), 32'd0);
    chk("lu_stall_before_edge", 32'(stall_cnt), 32'd0);
    tick();
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd_addr = 5'd0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'h55;
    #1;
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_release_valid", 32'(out_valid), 32'd1);
    chk("lu_operand2_imm", operand2, 32'hFFFF_FFFC);
    chk("lu_store_data", out_store_data, 32'h55);
    chk("lu_alu_op", 32'(alu_op), 32'd1);
    tick();
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0;

    // Forwarded value captured during a downstream stall survives
    drive_instr(32'h200, 5'd5, 32'h10, 5'd6, 32'h20, 32'd0, 1'b0, 3'b010, 5'd7);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'h77;
    #1;
    chk("stall_c1_operand1", operand1, 32'h77);
    tick();
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0;
    #1;
    chk("stall_c2_operand1", operand1, 32'h77);
    chk("stall_c2_in_ready", 32'(in_ready), 32'd0);
    chk("stall_c2_out_pc", out_pc, 32'h200);
    chk("stall_c2_operand2", operand2, 32'h20);
    tick();
    #1;
    chk("stall_c3_operand1", operand1, 32'h77);
    chk("stall_c3_alu_op", 32'(alu_op), 32'd2);

    // Flush beats a simultaneous accept
    out_ready = 1'b1;
    drive_instr(32'h300, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 3'b100, 5'd8);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_no_capture_pc", out_pc, 32'h200);

    // Reset while holding
    drive_instr(32'h400, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 3'b101, 5'd9);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("prereset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_operand1", operand1, 32'd0);
    chk("midreset_operand2", operand2, 32'd0);
    chk("midreset_out_pc", out_pc, 32'd0);
    chk("midreset_alu_op", 32'(alu_op), 32'd0);
    chk("midreset_rd_addr", 32'(out_rd_addr), 32'd0);
    chk("midreset_reg_write", 32'(out_reg_write), 32'd0);
    chk("midreset_mem_read", 32'(out_mem_read), 32'd0);
    chk("midreset_store_data", out_store_data, 32'd0);
    chk("midreset_stall_cnt", 32'(stall_cnt), 32'd0);

    // Streaming 8 instructions back to back
    out_ready = 1'b1;
    drive_instr(32'h1000, 5'd1, 32'd1, 5'd2, 32'd0, 32'd0, 1'b0, 3'b000, 5'd10);
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("stream%0d_op1", i), operand1, 32'(i + 1));
      if (i < 7) begin
        drive_instr(32'h1000 + 32'(4 * (i + 1)), 5'd1, 32'(i + 2), 5'd2, 32'd0, 32'd0, 1'b0,
                    3'b000, 5'd10);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    #1;
    chk("stream_end_valid", 32'(out_valid), 32'd0);

    // Stall counter saturation (4-bit counter)
    drive_instr(32'h2000, 5'd8, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd11);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd8;
    for (int i = 0; i < 14; i++) tick();
    #1;
    chk("sat_cnt_14", 32'(stall_cnt), 32'd14);
    tick();
    #1;
    chk("sat_cnt_15", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("sat_cnt_hold", 32'(stall_cnt), 32'd15);
    chk("sat_out_valid", 32'(out_valid), 32'd0);
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd_addr = 5'd0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
